if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Parametrised instruction queue between IF and ID, replacing the single 64-bit inst_rdata buffer.
//  Accepts fetch packets of up to FETCH_W contiguous instructions per cycle (pc, inst, meta per slot).
//  Delivers up to ISSUE_W oldest instructions per cycle to ID, in order.
//  Decouples the icache data_ok timing from ID stalls.
//  Flushed on exception/branch-redirect so squashed instructions never reach ID.
// PARAMETERS
//  FETCH_W  2   instructions per fetch packet (slots 0..FETCH_W-1)
//  ISSUE_W  2   max instructions presented/consumed per cycle
//  DEPTH    8   queue entries; power of two, >= FETCH_W+ISSUE_W
//  PC_W     32  pc width
//  INST_W   32  instruction width
//  META_W   40  per-slot opaque side info (excep_en, excep_type, branch/btb_hit/pht_state, pre_pc)
// PORTS
//  clk           in   1                 clock
//  rst           in   1                 synchronous reset, active-high
//  flush_i       in   1                 excep_flush / redirect: drop all contents
//  in_valid_i    in   1                 fetch packet present (IF ready_go && if_valid)
//  in_mask_i     in   FETCH_W           per-slot valid; thermometer from bit0 (e.g. 2'b01, 2'b11)
//  in_pc_i       in   FETCH_W*PC_W      slot k at [k*PC_W +: PC_W]
//  in_inst_i     in   FETCH_W*INST_W    slot k at [k*INST_W +: INST_W]
//  in_meta_i     in   FETCH_W*META_W    slot k at [k*META_W +: META_W]
//  in_ready_o    out  1                 queue can take a full packet this cycle
//  out_valid_o   out  ISSUE_W           bit i = (count > i); thermometer
//  out_pc_o      out  ISSUE_W*PC_W      entry head+i
//  out_inst_o    out  ISSUE_W*INST_W    entry head+i
//  out_meta_o    out  ISSUE_W*META_W    entry head+i
//  out_accept_i  in   CNT_IW            number of heads ID consumes (0..ISSUE_W), CNT_IW=$clog2(ISSUE_W+1)
//  count_o       out  $clog2(DEPTH+1)   occupied entries
// BEHAVIOUR
//  - Reset (rst=1 at posedge): head=tail=count=0. After reset: out_valid_o=0, in_ready_o=1, count_o=0.
//    out_pc/inst/meta_o are don't-care while their valid bit is 0.
//  - in_ready_o = (DEPTH-count) >= FETCH_W, from current count only; same-cycle pops are ignored.
//    No in_* -> in_ready_o combinational path.
//  - Push when in_valid_i && in_ready_o: n = popcount(in_mask_i) slots written at tail..tail+n-1 (mod DEPTH).
//    Slot k lands at tail+k. tail += n. mask=0 is a legal no-op.
//    A non-thermometer mask is a protocol violation; the bench asserts on it.
//  - in_valid_i while !in_ready_o: ignored; IF holds (its allowin derives from in_ready_o).
//  - Pop: out_accept_i=m, m <= popcount(out_valid_o); head += m (mod DEPTH).
//    m > valid count is a violation (assert).
//  - Push and pop in the same cycle both apply: count_next = count + n - m.
//  - Zero-latency output: outputs decode registered storage at head. Pushed instruction is visible the next cycle.
//    No bypass from in_* to out_*.
//  - Pointers: $clog2(DEPTH) bits, natural wrap. Full: count==DEPTH. Empty: count==0.
//  - flush_i: highest priority below rst. Next cycle head=tail=count=0; same-cycle push and pop are discarded.
//    in_ready_o and out_valid_o are unaffected in the flush cycle itself.
//  - Entries with meta excep_en set are stored and issued like others; the queue does not inspect meta.
//  - Storage registers are not reset (data only); valid is derived solely from count.
// STRUCTURE
//  - Constants in header DefineFetchQueue.h: FqFetchW, FqIssueW, FqDepth, FqMetaW,
//    slot packing macros, and the META field layout (ExcepEn, ExcepType, Branch, BtbHit, PhtState, PrePc).
//  - Sub-module if_fq_regfile: DEPTH x (PC_W+INST_W+META_W) flops,
//    FETCH_W write ports (wptr+k, we_k) and ISSUE_W read ports (rptr+i).
//  - Top holds head/tail/count, popcount of in_mask_i, ready/valid logic and flush.
// TESTING
//  - Reset then idle: count_o=0, out_valid_o=2'b00, in_ready_o=1 for 10 cycles.
//  - Push pc 0x1c000000/0x1c000004 mask 2'b11, accept 0 -> next cycle out_valid=2'b11, out_pc slot0=0x1c000000, slot1=0x1c000004, count=2.
//  - Fill: 4 pushes of mask 2'b11, no pops -> count=8, in_ready_o=0; 5th packet ignored, contents unchanged.
//  - Wrap: push mask 2'b01 (pc 0x..08), then alternate push 2'b11 / accept 2 for 10 cycles -> pcs emerge strictly ascending across pointer wrap, count stays 1..3.
//  - Simultaneous: count=6, push 2'b11 and accept 2 -> count=6 next cycle, in_ready_o=1, head advanced by 2.
//  - Flush with push+accept active at count=5 -> next cycle count=0, out_valid=0, in_ready=1; pushed packet absent.
//  - Flush then rst mid-stream -> count=0 either way.
//  - Sweep FETCH_W=4/ISSUE_W=2/DEPTH=16 against a scoreboard FIFO model.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg
//   Shared constants for the IF->ID instruction queue: default geometry
//   (fetch width, issue width, depth, field widths) and the bit layout of
//   the per-slot meta word carried alongside each instruction.
//   The queue itself never looks inside meta; the layout lives here so that
//   IF (producer) and ID (consumer) agree on it.
package if_fetch_queue_pkg;

  localparam int FQ_FETCH_W = 2;
  localparam int FQ_ISSUE_W = 2;
  localparam int FQ_DEPTH   = 8;
  localparam int FQ_PC_W    = 32;
  localparam int FQ_INST_W  = 32;
  localparam int FQ_META_W  = 40;

  // Meta field layout, LSB first.
  localparam int FQ_META_EXCEP_EN_LSB   = 0;
  localparam int FQ_META_EXCEP_TYPE_LSB = 1;
  localparam int FQ_META_EXCEP_TYPE_W   = 3;
  localparam int FQ_META_BRANCH_LSB     = 4;
  localparam int FQ_META_BTB_HIT_LSB    = 5;
  localparam int FQ_META_PHT_STATE_LSB  = 6;
  localparam int FQ_META_PHT_STATE_W    = 2;
  localparam int FQ_META_PRE_PC_LSB     = 8;
  localparam int FQ_META_PRE_PC_W       = 32;

  typedef struct packed {
    logic [FQ_META_PRE_PC_W-1:0]     pre_pc;
    logic [FQ_META_PHT_STATE_W-1:0]  pht_state;
    logic                            btb_hit;
    logic                            branch;
    logic [FQ_META_EXCEP_TYPE_W-1:0] excep_type;
    logic                            excep_en;
  } fq_meta_t;

endpackage

// File: rtl/if_fq_regfile.sv
// if_fq_regfile
//   Circular storage for the fetch queue: DEPTH entries of WIDTH bits.
//   Entries are data only and are never reset; validity is tracked by the
//   owner through its occupancy count.
// Ports
//   clk    clock
//   wptr   base write index; write port k targets wptr+k (mod DEPTH)
//   we     per-port write enable
//   wdata  write data, port k at [k*WIDTH +: WIDTH]
//   rptr   base read index; read port i returns entry rptr+i (mod DEPTH)
//   rdata  combinational read data, port i at [i*WIDTH +: WIDTH]
module if_fq_regfile
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH    = FQ_DEPTH,
  parameter int WIDTH    = FQ_PC_W + FQ_INST_W + FQ_META_W,
  parameter int WR_PORTS = FQ_FETCH_W,
  parameter int RD_PORTS = FQ_ISSUE_W,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic [PTR_W-1:0]          wptr,
  input  logic [WR_PORTS-1:0]       we,
  input  logic [WR_PORTS*WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0]          rptr,
  output logic [RD_PORTS*WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write ports always hit distinct entries, so the loop never collides;
  // pointer arithmetic wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WR_PORTS; k++) begin
      if (we[k]) begin
        mem[wptr + PTR_W'(k)] <= wdata[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      rdata[i*WIDTH +: WIDTH] = mem[rptr + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction queue between IF and ID. Takes fetch packets of up to
//   FETCH_W contiguous instructions, hands the ISSUE_W oldest entries to ID
//   each cycle, and drops everything on flush so squashed instructions never
//   reach decode.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   flush_i       drop all contents (exception / redirect)
//   in_valid_i    fetch packet present
//   in_mask_i     per-slot valid, thermometer from bit 0
//   in_pc_i       slot k pc at [k*PC_W +: PC_W]
//   in_inst_i     slot k instruction at [k*INST_W +: INST_W]
//   in_meta_i     slot k meta at [k*META_W +: META_W]
//   in_ready_o    a full packet fits this cycle
//   out_valid_o   bit i set when entry head+i is occupied
//   out_pc_o      pc of entry head+i
//   out_inst_o    instruction of entry head+i
//   out_meta_o    meta of entry head+i
//   out_accept_i  number of head entries ID consumes this cycle
//   count_o       occupied entries
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int FETCH_W = FQ_FETCH_W,
  parameter int ISSUE_W = FQ_ISSUE_W,
  parameter int DEPTH   = FQ_DEPTH,
  parameter int PC_W    = FQ_PC_W,
  parameter int INST_W  = FQ_INST_W,
  parameter int META_W  = FQ_META_W,
  localparam int CNT_IW = $clog2(ISSUE_W + 1),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  input  logic [FETCH_W-1:0]          in_mask_i,
  input  logic [FETCH_W*PC_W-1:0]     in_pc_i,
  input  logic [FETCH_W*INST_W-1:0]   in_inst_i,
  input  logic [FETCH_W*META_W-1:0]   in_meta_i,
  output logic                        in_ready_o,
  output logic [ISSUE_W-1:0]          out_valid_o,
  output logic [ISSUE_W*PC_W-1:0]     out_pc_o,
  output logic [ISSUE_W*INST_W-1:0]   out_inst_o,
  output logic [ISSUE_W*META_W-1:0]   out_meta_o,
  input  logic [CNT_IW-1:0]           out_accept_i,
  output logic [CNT_W-1:0]            count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PC_W + INST_W + META_W;

  logic [PTR_W-1:0]           head;
  logic [PTR_W-1:0]           tail;
  logic [CNT_W-1:0]           count;
  logic [CNT_W-1:0]           push_n;
  logic [CNT_W-1:0]           push_amt;
  logic                       push_fire;
  logic [FETCH_W-1:0]         we;
  logic [FETCH_W*ENT_W-1:0]   wdata;
  logic [ISSUE_W*ENT_W-1:0]   rdata;

  // Ready looks only at the registered count so IF's allowin never depends
  // on anything arriving this cycle; same-cycle pops are deliberately ignored.
  assign in_ready_o = (count <= CNT_W'(DEPTH - FETCH_W));
  assign push_fire  = in_valid_i && in_ready_o;
  assign push_amt   = push_fire ? push_n : '0;
  assign count_o    = count;

  always_comb begin
    push_n = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (in_mask_i[k]) begin
        push_n = push_n + CNT_W'(1);
      end
    end
  end

  // Thermometer mask means slot k simply lands at tail+k. Writes are
  // suppressed on flush so a squashed packet never touches storage.
  always_comb begin
    we    = '0;
    wdata = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      we[k] = push_fire && in_mask_i[k] && !flush_i;
      wdata[k*ENT_W +: ENT_W] = {in_pc_i[k*PC_W +: PC_W],
                                 in_inst_i[k*INST_W +: INST_W],
                                 in_meta_i[k*META_W +: META_W]};
    end
  end

  if_fq_regfile #(
    .DEPTH    (DEPTH),
    .WIDTH    (ENT_W),
    .WR_PORTS (FETCH_W),
    .RD_PORTS (ISSUE_W)
  ) u_regfile (
    .clk   (clk),
    .wptr  (tail),
    .we    (we),
    .wdata (wdata),
    .rptr  (head),
    .rdata (rdata)
  );

  // Outputs decode storage at head directly; validity comes only from count.
  always_comb begin
    out_valid_o = '0;
    out_pc_o    = '0;
    out_inst_o  = '0;
    out_meta_o  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      out_valid_o[i]               = (count > CNT_W'(i));
      out_pc_o[i*PC_W +: PC_W]     = rdata[i*ENT_W + INST_W + META_W +: PC_W];
      out_inst_o[i*INST_W +: INST_W] = rdata[i*ENT_W + META_W +: INST_W];
      out_meta_o[i*META_W +: META_W] = rdata[i*ENT_W +: META_W];
    end
  end

  // Flush outranks push and pop: whatever else happens this cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(out_accept_i);
      tail  <= tail + PTR_W'(push_amt);
      count <= count + push_amt - CNT_W'(out_accept_i);
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue
//   Directed checks of the default 2/2/8 queue followed by a randomised
//   sweep of a 4/2/16 instance against a FIFO model.
module tb_if_fetch_queue;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   in_mask = '0;
  logic [63:0]  in_pc = '0;
  logic [63:0]  in_inst = '0;
  logic [79:0]  in_meta = '0;
  logic         in_ready;
  logic [1:0]   out_valid;
  logic [63:0]  out_pc;
  logic [63:0]  out_inst;
  logic [79:0]  out_meta;
  logic [1:0]   out_accept = '0;
  logic [3:0]   count;

  logic         flush4 = 1'b0;
  logic         in_valid4 = 1'b0;
  logic [3:0]   in_mask4 = '0;
  logic [127:0] in_pc4 = '0;
  logic [127:0] in_inst4 = '0;
  logic [159:0] in_meta4 = '0;
  logic         in_ready4;
  logic [1:0]   out_valid4;
  logic [63:0]  out_pc4;
  logic [63:0]  out_inst4;
  logic [79:0]  out_meta4;
  logic [1:0]   out_accept4 = '0;
  logic [4:0]   count4;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  logic [31:0] sweep_pc = 32'h8000_0000;
  logic [31:0] push_pc;
  logic [31:0] head_pc;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_mask_i    (in_mask),
    .in_pc_i      (in_pc),
    .in_inst_i    (in_inst),
    .in_meta_i    (in_meta),
    .in_ready_o   (in_ready),
    .out_valid_o  (out_valid),
    .out_pc_o     (out_pc),
    .out_inst_o   (out_inst),
    .out_meta_o   (out_meta),
    .out_accept_i (out_accept),
    .count_o      (count)
  );

  if_fetch_queue #(
    .FETCH_W (4),
    .ISSUE_W (2),
    .DEPTH   (16)
  ) dut4 (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush4),
    .in_valid_i   (in_valid4),
    .in_mask_i    (in_mask4),
    .in_pc_i      (in_pc4),
    .in_inst_i    (in_inst4),
    .in_meta_i    (in_meta4),
    .in_ready_o   (in_ready4),
    .out_valid_o  (out_valid4),
    .out_pc_o     (out_pc4),
    .out_inst_o   (out_inst4),
    .out_meta_o   (out_meta4),
    .out_accept_i (out_accept4),
    .count_o      (count4)
  );

  // Drive one packet/accept/flush onto the default instance. Slot 1 pc is
  // slot 0 pc + 4; inst is the inverted pc, meta is 8'hA5 above the pc.
  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [31:0] pc0,
                               input logic [1:0] acc, input logic fl);
    logic [1:0] nvalid;
    nvalid = 2'(out_valid[0]) + 2'(out_valid[1]);
    assert ((m & (m + 2'd1)) == 2'd0) else $error("[TB] protocol violation: mask %b", m);
    assert (acc <= nvalid) else $error("[TB] protocol violation: accept %0d > valid %0d", acc, nvalid);
    in_valid   = v;
    in_mask    = m;
    in_pc      = {pc0 + 32'd4, pc0};
    in_inst    = ~in_pc;
    in_meta    = {8'hA5, pc0 + 32'd4, 8'hA5, pc0};
    out_accept = acc;
    flush      = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkStatus(input string tag, input int c, input logic [1:0] v, input logic r);
    checkOutput({tag, ".count"}, 64'(count), 64'(c));
    checkOutput({tag, ".valid"}, 64'(out_valid), 64'(v));
    checkOutput({tag, ".ready"}, 64'(in_ready), 64'(r));
  endtask

  initial begin
    applyStimulus(1'b0, 2'b00, 32'h0, 2'd0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checkStatus("reset", 0, 2'b00, 1'b1);
    for (int c = 0; c < 10; c++) begin
      step();
      checkStatus("idle", 0, 2'b00, 1'b1);
    end

    // First packet becomes visible the cycle after it is pushed.
    applyStimulus(1'b1, 2'b11, 32'h1c00_0000, 2'd0, 1'b0);
    step();
    checkStatus("push1", 2, 2'b11, 1'b1);
    checkOutput("push1.pc0", 64'(out_pc[31:0]), 64'h1c00_0000);
    checkOutput("push1.pc1", 64'(out_pc[63:32]), 64'h1c00_0004);
    checkOutput("push1.inst0", 64'(out_inst[31:0]), 64'he3ff_ffff);
    checkOutput("push1.meta1", 64'(out_meta[79:40]), 64'h00_00a5_1c00_0004);

    // Fill to eight entries; the fifth packet must bounce.
    applyStimulus(1'b1, 2'b11, 32'h1c00_0008, 2'd0, 1'b0);
    step();
    checkStatus("fill2", 4, 2'b11, 1'b1);
    applyStimulus(1'b1, 2'b11, 32'h1c00_0010, 2'd0, 1'b0);
    step();
    checkStatus("fill3", 6, 2'b11, 1'b1);
    applyStimulus(1'b1, 2'b11, 32'h1c00_0018, 2'd0, 1'b0);
    step();
    checkStatus("fill4", 8, 2'b11, 1'b0);
    applyStimulus(1'b1, 2'b11, 32'h2000_0000, 2'd0, 1'b0);
    step();
    checkStatus("full_hold", 8, 2'b11, 1'b0);
    checkOutput("full_hold.pc0", 64'(out_pc[31:0]), 64'h1c00_0000);
    checkOutput("full_hold.pc1", 64'(out_pc[63:32]), 64'h1c00_0004);

    applyStimulus(1'b0, 2'b00, 32'h0, 2'd2, 1'b0);
    step();
    checkStatus("drain1", 6, 2'b11, 1'b1);
    checkOutput("drain1.pc0", 64'(out_pc[31:0]), 64'h1c00_0008);
    step();
    checkStatus("drain2", 4, 2'b11, 1'b1);
    checkOutput("drain2.pc0", 64'(out_pc[31:0]), 64'h1c00_0010);
    step();
    checkStatus("drain3", 2, 2'b11, 1'b1);
    checkOutput("drain3.pc0", 64'(out_pc[31:0]), 64'h1c00_0018);
    checkOutput("drain3.pc1", 64'(out_pc[63:32]), 64'h1c00_001c);
    applyStimulus(1'b0, 2'b00, 32'h0, 2'd2, 1'b0);
    step();
    checkStatus("drain4", 0, 2'b00, 1'b1);

    applyStimulus(1'b1, 2'b00, 32'h3000_0000, 2'd0, 1'b0);
    step();
    checkStatus("mask0", 0, 2'b00, 1'b1);

    // Single-slot seed, then alternate push/pop so head and tail cross the wrap.
    applyStimulus(1'b1, 2'b01, 32'h1c00_0100, 2'd0, 1'b0);
    step();
    checkStatus("wrap_seed", 1, 2'b01, 1'b1);
    checkOutput("wrap_seed.pc0", 64'(out_pc[31:0]), 64'h1c00_0100);
    push_pc = 32'h1c00_0104;
    head_pc = 32'h1c00_0100;
    for (int c = 0; c < 10; c++) begin
      if (c % 2 == 0) begin
        applyStimulus(1'b1, 2'b11, push_pc, 2'd0, 1'b0);
        push_pc = push_pc + 32'd8;
      end else begin
        applyStimulus(1'b0, 2'b00, 32'h0, 2'd2, 1'b0);
        head_pc = head_pc + 32'd8;
      end
      step();
      if (c % 2 == 0) begin
        checkStatus("wrap_push", 3, 2'b11, 1'b1);
        checkOutput("wrap_push.pc1", 64'(out_pc[63:32]), 64'(head_pc + 32'd4));
      end else begin
        checkStatus("wrap_pop", 1, 2'b01, 1'b1);
      end
      checkOutput("wrap.pc0", 64'(out_pc[31:0]), 64'(head_pc));
    end
    applyStimulus(1'b0, 2'b00, 32'h0, 2'd1, 1'b0);
    step();
    checkStatus("wrap_drain", 0, 2'b00, 1'b1);

    // Push and pop together at count 6.
    applyStimulus(1'b1, 2'b11, 32'h1c00_0200, 2'd0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b11, 32'h1c00_0208, 2'd0, 1'b0);
    step();
    applyStimulus(1'b1, 2'b11, 32'h1c00_0210, 2'd0, 1'b0);
    step();
    checkStatus("sim_pre", 6, 2'b11, 1'b1);
    applyStimulus(1'b1, 2'b11, 32'h1c00_0218, 2'd2, 1'b0);
    step();
    checkStatus("sim", 6, 2'b11, 1'b1);
    checkOutput("sim.pc0", 64'(out_pc[31:0]), 64'h1c00_0208);
    checkOutput("sim.pc1", 64'(out_pc[63:32]), 64'h1c00_020c);

    // Flush at count 5 with a push and a pop pending.
    applyStimulus(1'b0, 2'b00, 32'h0, 2'd1, 1'b0);
    step();
    checkStatus("flush_pre", 5, 2'b11, 1'b1);
    checkOutput("flush_pre.pc0", 64'(out_pc[31:0]), 64'h1c00_020c);
    applyStimulus(1'b1, 2'b11, 32'h1c00_0300, 2'd2, 1'b1);
    #1;
    checkStatus("flush_cycle", 5, 2'b11, 1'b1);
    step();
    checkStatus("flush", 0, 2'b00, 1'b1);
    applyStimulus(1'b1, 2'b11, 32'h1c00_0400, 2'd0, 1'b0);
    step();
    checkStatus("post_flush", 2, 2'b11, 1'b1);
    checkOutput("post_flush.pc0", 64'(out_pc[31:0]), 64'h1c00_0400);
    checkOutput("post_flush.pc1", 64'(out_pc[63:32]), 64'h1c00_0404);

    // Flush, then reset, in the middle of traffic.
    applyStimulus(1'b1, 2'b11, 32'h1c00_0500, 2'd0, 1'b0);
    step();
    checkStatus("mid_fill", 4, 2'b11, 1'b1);
    applyStimulus(1'b0, 2'b00, 32'h0, 2'd0, 1'b1);
    step();
    checkStatus("mid_flush", 0, 2'b00, 1'b1);
    applyStimulus(1'b1, 2'b11, 32'h1c00_0600, 2'd0, 1'b0);
    step();
    checkStatus("mid_refill", 2, 2'b11, 1'b1);
    applyStimulus(1'b1, 2'b11, 32'h1c00_0700, 2'd1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkStatus("mid_rst", 0, 2'b00, 1'b1);
    applyStimulus(1'b0, 2'b00, 32'h0, 2'd0, 1'b0);

    // Randomised sweep of the wide instance against a FIFO of pcs.
    for (int c = 0; c < 400; c++) begin
      int          n;
      int          m;
      int          sz;
      logic        rdy;
      logic        v;
      logic        fl;
      logic [31:0] inv;
      sz  = sb.size();
      rdy = ((16 - sz) >= 4);
      checkOutput("sweep.count", 64'(count4), 64'(sz));
      checkOutput("sweep.ready", 64'(in_ready4), 64'(rdy));
      checkOutput("sweep.valid", 64'(out_valid4), 64'({sz > 1, sz > 0}));
      if (sz > 0) begin
        inv = ~sb[0];
        checkOutput("sweep.pc0", 64'(out_pc4[31:0]), 64'(sb[0]));
        checkOutput("sweep.inst0", 64'(out_inst4[31:0]), 64'(inv));
      end
      if (sz > 1) begin
        checkOutput("sweep.pc1", 64'(out_pc4[63:32]), 64'(sb[1]));
      end
      n  = int'($urandom_range(0, 4));
      v  = ($urandom_range(0, 3) != 0);
      m  = int'($urandom_range(0, (sz < 2) ? sz : 2));
      fl = ($urandom_range(0, 19) == 0);
      in_valid4   = v;
      in_mask4    = 4'((1 << n) - 1);
      for (int k = 0; k < 4; k++) begin
        in_pc4[k*32 +: 32]   = sweep_pc + 32'(4 * k);
        in_inst4[k*32 +: 32] = ~(sweep_pc + 32'(4 * k));
        in_meta4[k*40 +: 40] = {8'h5A, sweep_pc + 32'(4 * k)};
      end
      out_accept4 = 2'(m);
      flush4      = fl;
      if (fl) begin
        sb.delete();
      end else begin
        repeat (m) void'(sb.pop_front());
        if (v && rdy) begin
          for (int k = 0; k < n; k++) sb.push_back(sweep_pc + 32'(4 * k));
          sweep_pc = sweep_pc + 32'(4 * n);
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
